// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared types and constants for the memory dump reader.
//   state_e    - reader FSM states
//   HALF_WIDTH - width of one emitted halfword
//   LO_FIRST   - halfword ordering; low half of each word goes out first,
//                matching the image loader's (2i, 2i+1) -> word i packing
package mem_dump_pkg;

  localparam int HALF_WIDTH = 16;
  localparam bit LO_FIRST   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND_LO,
    SEND_HI,
    DONE
  } state_e;

  // Pick the upper (upper=1) or lower half of a memory word.
  function automatic logic [HALF_WIDTH-1:0] half_sel(
    input logic [2*HALF_WIDTH-1:0] w,
    input logic                    upper
  );
    return upper ? w[2*HALF_WIDTH-1:HALF_WIDTH] : w[HALF_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mem_dump_splitter.sv
// mem_dump_splitter: holds one memory word and presents it as two halfwords
// on a valid/ready stream, holding data/last stable under backpressure.
//   clock, reset  - system clock, synchronous active-high reset
//   load_i        - capture word_i and start presenting its first half
//   word_i        - memory word to split
//   last_word_i   - the buffered word is the final one of the dump
//   hw_ready_i    - sink ready
//   hw_data_o     - registered halfword
//   hw_valid_o    - registered valid
//   hw_last_o     - registered last marker (second half of final word only)
import mem_dump_pkg::*;

module mem_dump_splitter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  last_word_i,
  input  logic                  hw_ready_i,
  output logic [HALF_WIDTH-1:0] hw_data_o,
  output logic                  hw_valid_o,
  output logic                  hw_last_o
);

  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [HALF_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  second_q, second_d;  // presenting the second half

  always_comb begin
    buf_d    = buf_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    second_d = second_q;
    if (load_i) begin
      buf_d    = word_i;
      data_d   = half_sel(word_i, !LO_FIRST);
      valid_d  = 1'b1;
      last_d   = 1'b0;
      second_d = 1'b0;
    end else if (valid_q && hw_ready_i) begin
      if (!second_q) begin
        data_d   = half_sel(buf_q, LO_FIRST);
        last_d   = last_word_i;
        second_d = 1'b1;
      end else begin
        // data is left as-is; only valid/last drop after the final half
        valid_d  = 1'b0;
        last_d   = 1'b0;
        second_d = 1'b0;
      end
    end
    // Without a handshake every register holds, which keeps data/last
    // stable while the sink stalls.
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      second_q <= second_d;
    end
  end

  assign hw_data_o  = data_q;
  assign hw_valid_o = valid_q;
  assign hw_last_o  = last_q;

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads word_count words starting at start_addr through a
// synchronous-read memory port and streams each as two halfwords, low first.
//   clock, reset   - system clock, synchronous active-high reset
//   start          - one-cycle request, only honoured in IDLE
//   start_addr     - first word address
//   word_count     - words to dump, 0..2^ADDR_WIDTH
//   busy, done     - activity flag and one-cycle completion pulse
//   mem_addr/re    - memory read port (data returns next cycle)
//   mem_rdata      - memory read data
//   hw_data/valid/ready/last - halfword output stream
import mem_dump_pkg::*;

module mem_dump_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32  // must be 2*HALF_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [HALF_WIDTH-1:0] hw_data,
  output logic                  hw_valid,
  input  logic                  hw_ready,
  output logic                  hw_last
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // next word to read
  logic [ADDR_WIDTH:0]   rem_q, rem_d;        // words not yet read
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;    // held memory address
  logic                  load;
  logic                  hs;

  assign hs = hw_valid && hw_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    maddr_d = maddr_q;
    mem_re  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = start_addr;
          rem_d  = word_count;
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            maddr_d = start_addr;
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_re  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        load    = 1'b1;
        addr_d  = addr_q + ADDR_WIDTH'(1);   // wraps at 2^ADDR_WIDTH
        rem_d   = rem_q - (ADDR_WIDTH+1)'(1);
        state_d = SEND_LO;
      end
      SEND_LO: begin
        if (hs) state_d = SEND_HI;
      end
      SEND_HI: begin
        if (hs) begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            // address only moves when the next read is issued
            maddr_d = addr_q;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      maddr_q <= maddr_d;
    end
  end

  assign mem_addr = maddr_q;
  assign busy     = (state_q == READ) || (state_q == WAIT) ||
                    (state_q == SEND_LO) || (state_q == SEND_HI);
  assign done     = (state_q == DONE);

  // rem_q has already been decremented by the time the second half is
  // reached, so zero means this is the final word.
  mem_dump_splitter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_split (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .word_i      (mem_rdata),
    .last_word_i (rem_q == '0),
    .hw_ready_i  (hw_ready),
    .hw_data_o   (hw_data),
    .hw_valid_o  (hw_valid),
    .hw_last_o   (hw_last)
  );

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [8:0]  start_addr = 0;
  logic [9:0]  word_count = 0;
  logic        busy, done, mem_re, hw_valid, hw_last;
  logic        hw_ready = 1;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata = 0;
  logic [15:0] hw_data;

  logic [31:0] mem [512];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int rmode = 0;

  logic [16:0] gotq [$];   // {last, data} per handshake
  logic [8:0]  gota [$];   // address of each read

  mem_dump_reader dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .hw_data(hw_data),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_last(hw_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes, reads, and stability under stall.
  bit          stall_prev = 0;
  logic [16:0] stall_val;
  always @(negedge clock) begin
    if (!reset) begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, hw_valid}, 32'd1);
        chk("stall_data", {15'b0, hw_last, hw_data}, {15'b0, stall_val});
      end
      if (hw_valid && hw_ready) begin
        gotq.push_back({hw_last, hw_data});
        last_hs_cyc = cyc;
      end
      if (mem_re) gota.push_back(mem_addr);
    end
    stall_prev = hw_valid && !hw_ready && !reset;
    stall_val  = {hw_last, hw_data};
  end

  // Sink ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    forever begin
      @(posedge clock); #1;
      case (rmode)
        0: hw_ready = 1;
        1: begin hw_ready = pat[ph % 4]; ph++; end
        default: hw_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic run_dump(input int sa, input int cnt, input int mode, input bit poke);
    logic [16:0] expq [$];
    logic [8:0]  expa [$];
    logic [31:0] w;
    int n;
    for (int i = 0; i < cnt; i++) begin
      w = mem[(sa + i) % 512];
      expq.push_back({1'b0, w[15:0]});
      expq.push_back({(i == cnt - 1) ? 1'b1 : 1'b0, w[31:16]});
      expa.push_back(9'((sa + i) % 512));
    end
    rmode = mode;
    step();
    gotq.delete(); gota.delete();
    start = 1; start_addr = 9'(sa); word_count = 10'(cnt);
    step();                       // now in cycle N+1
    start = 0;
    if (cnt == 0) begin
      chk("z_done", {31'b0, done}, 1);
      chk("z_mem_re", {31'b0, mem_re}, 0);
      chk("z_valid", {31'b0, hw_valid}, 0);
      chk("z_busy", {31'b0, busy}, 0);
      step();
      chk("z_done_off", {31'b0, done}, 0);
      step(); step();
    end else begin
      chk("n1_mem_re", {31'b0, mem_re}, 1);
      chk("n1_busy", {31'b0, busy}, 1);
      chk("n1_mem_addr", {23'b0, mem_addr}, 32'(sa));
      step();
      chk("n2_valid", {31'b0, hw_valid}, 0);
      step();
      chk("n3_valid", {31'b0, hw_valid}, 1);
      chk("n3_data", {15'b0, hw_last, hw_data}, {15'b0, expq[0]});
      if (poke) begin
        start = 1; start_addr = 9'(sa + 7); word_count = 10'd1;
        step();
        start = 0;
      end
      n = 0;
      while (!done && n < 6000) begin step(); n++; end
      chk("done_seen", {31'b0, done}, 1);
      chk("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
      chk("done_busy", {31'b0, busy}, 0);
      if (poke) start = 1;        // start in DONE must be ignored
      step();
      start = 0;
      chk("after_done", {31'b0, done}, 0);
      chk("after_busy", {31'b0, busy}, 0);
      chk("after_mem_re", {31'b0, mem_re}, 0);
      step();
      chk("after2_mem_re", {31'b0, mem_re}, 0);
    end
    chk("hw_count", 32'(gotq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < gotq.size(); i++)
      chk($sformatf("hw[%0d]", i), {15'b0, gotq[i]}, {15'b0, expq[i]});
    chk("rd_count", 32'(gota.size()), 32'(expa.size()));
    for (int i = 0; i < expa.size() && i < gota.size(); i++)
      chk($sformatf("rd[%0d]", i), {23'b0, gota[i]}, {23'b0, expa[i]});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0] = 32'h0002_0001;
    mem[1] = 32'h0004_0003;

    // reset state
    step(); step();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mem_re", {31'b0, mem_re}, 0);
    chk("rst_valid", {31'b0, hw_valid}, 0);
    chk("rst_last", {31'b0, hw_last}, 0);
    chk("rst_data", {16'b0, hw_data}, 0);
    chk("rst_addr", {23'b0, mem_addr}, 0);
    reset = 0;
    step();

    run_dump(0, 2, 0, 0);         // basic, always ready
    run_dump(0, 2, 1, 0);         // ready 1,0,0,1 backpressure
    run_dump(5, 0, 0, 0);         // empty dump

    mem[511] = 32'hBBBB_AAAA;
    mem[0]   = 32'hDDDD_CCCC;
    run_dump(511, 2, 0, 0);       // address wrap
    run_dump(3, 3, 0, 1);         // start ignored during SEND_LO and DONE

    // reset in SEND_HI of word 0
    rmode = 0;
    step();
    start = 1; start_addr = 0; word_count = 2;
    step(); start = 0;            // N+1
    step(); step(); step();       // N+4: SEND_HI
    chk("rs_hi_data", {16'b0, hw_data}, {16'b0, mem[0][31:16]});
    reset = 1;
    step();
    reset = 0;
    chk("rs_valid", {31'b0, hw_valid}, 0);
    chk("rs_data", {16'b0, hw_data}, 0);
    chk("rs_last", {31'b0, hw_last}, 0);
    chk("rs_busy", {31'b0, busy}, 0);
    chk("rs_mem_re", {31'b0, mem_re}, 0);
    chk("rs_addr", {23'b0, mem_addr}, 0);
    for (int k = 0; k < 4; k++) begin
      chk("rs_done", {31'b0, done}, 0);
      chk("rs_idle_valid", {31'b0, hw_valid}, 0);
      step();
    end
    run_dump(0, 2, 0, 0);         // works normally after reset

    run_dump(100, 512, 0, 0);     // full memory, wraps once

    for (int k = 0; k < 8; k++)
      run_dump(int'($urandom_range(0, 511)), int'($urandom_range(1, 6)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
